mips_multicycle_ctrl: RTL and testbench

- Multi-cycle MIPS control unit, successor to the single-cycle decoder.
- Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps over a shared ALU and unified memory.
- Supports a memory-ready handshake for wait states, a parametrised ALUControl width, and a retired-instruction counter.
- Sits between instruction register (Op/Funct), datapath (Zero) and memory (MemReady).

---
 rtl/mips_multicycle_ctrl_if.sv | 40 ++++
 rtl/mips_multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit bundle: instruction fields, datapath/memory status in; datapath and memory controls out.
// Latency: none, wires only.
// Backpressure: MemReady from memory stretches FETCH, MEMREAD and MEMWR.
interface mips_multicycle_ctrl_if #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
);
  logic [5:0]           Op;
  logic [5:0]           Funct;
  logic                 Zero;
  logic                 MemReady;
  logic                 IorD;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegDst;
  logic                 MemtoReg;
  logic                 RegWrite;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           PCSrc;
  logic                 PCEn;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 IllegalOp;
  logic [3:0]           State;
  logic [CNT_W-1:0]     InstrCount;

  // Controller side
  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State, InstrCount
  );

  // Datapath / memory side
  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State, InstrCount
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (Moore) with retired-fetch counter; MIPS_MC_CTRL_BNE_EN adds bne.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles with no wait states.
// Backpressure: each MemReady=0 cycle in FETCH/MEMREAD/MEMWR holds the state one more cycle.
module mips_multicycle_ctrl #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MIPS_MC_CTRL_BNE_EN
  logic             bne_q, bne_d;
`endif

  // Next-state and counter logic; unreachable codes fall back to FETCH
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef MIPS_MC_CTRL_BNE_EN
    bne_d   = bne_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (bus.MemReady) begin
          state_d = S_DECODE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ: begin
            state_d = S_BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
            bne_d   = 1'b0;
`endif
          end
`ifdef MIPS_MC_CTRL_BNE_EN
          OP_BNE: begin
            state_d = S_BRANCH;
            bne_d   = 1'b1;
          end
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR is stable after FETCH, so Op still tells lw from sw here
      S_MEMADR:  state_d = (bus.Op == OP_SW) ? S_MEMWR : S_MEMREAD;
      S_MEMREAD: if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWR:   if (bus.MemReady) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
`ifdef MIPS_MC_CTRL_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MIPS_MC_CTRL_BNE_EN
      bne_q   <= bne_d;
`endif
    end
  end

  // Output decode from current state; in reset every output shows idle FETCH values
  always_comb begin
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.PCSrc      = 2'b00;
    bus.PCEn       = 1'b0;
    bus.ALUControl = ALU_ADD;
    bus.IllegalOp  = 1'b0;
    bus.State      = 4'd0;
    bus.InstrCount = '0;
    if (!rst_n) begin
      bus.ALUSrcB = 2'b01;
    end else begin
      bus.State      = state_q;
      bus.InstrCount = cnt_q;
      case (state_q)
        S_FETCH: begin
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.MemReady;
          bus.PCEn    = bus.MemReady;
        end
        S_DECODE: begin
          bus.ALUSrcB   = 2'b11;
          // Only an unrecognised opcode sends DECODE straight back to FETCH
          bus.IllegalOp = (state_d == S_FETCH);
        end
        S_MEMADR, S_ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MEMREAD: bus.IorD = 1'b1;
        S_MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
        end
        S_EXEC: begin
          bus.ALUSrcA = 1'b1;
          case (bus.Funct)
            6'b100000: bus.ALUControl = ALU_ADD;
            6'b100010: bus.ALUControl = ALU_SUB;
            6'b100100: bus.ALUControl = ALU_AND;
            6'b100101: bus.ALUControl = ALU_OR;
            6'b101010: bus.ALUControl = ALU_SLT;
            default:   bus.IllegalOp  = 1'b1;
          endcase
        end
        S_ALUWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = ALU_SUB;
          bus.PCSrc      = 2'b01;
`ifdef MIPS_MC_CTRL_BNE_EN
          bus.PCEn       = bne_q ? ~bus.Zero : bus.Zero;
`else
          bus.PCEn       = bus.Zero;
`endif
        end
        S_ADDIWB: bus.RegWrite = 1'b1;
        S_JUMP: begin
          bus.PCSrc = 2'b10;
          bus.PCEn  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: default DUT (ALUCTRL_W=4, CNT_W=32) and narrow DUT (ALUCTRL_W=6, CNT_W=4)
// share one stimulus stream; expected values are hand-computed constants.
// Inputs change 2 ns after the rising edge, outputs are sampled 1 ns later.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mr;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.ALUCTRL_W(4), .CNT_W(32)) bus_a ();
  mips_multicycle_ctrl_if #(.ALUCTRL_W(6), .CNT_W(4))  bus_b ();

  assign bus_a.Op = op;  assign bus_a.Funct = funct;  assign bus_a.Zero = zero;  assign bus_a.MemReady = mr;
  assign bus_b.Op = op;  assign bus_b.Funct = funct;  assign bus_b.Zero = zero;  assign bus_b.MemReady = mr;

  mips_multicycle_ctrl #(.ALUCTRL_W(4), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mips_multicycle_ctrl #(.ALUCTRL_W(6), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mr = 1'b1;
    tick(); tick();
    settle();
    chk("rst_state", 32'(bus_a.State), 32'd0);
    chk("rst_alusrcb", 32'(bus_a.ALUSrcB), 32'd1);
    chk("rst_aluctl", 32'(bus_a.ALUControl), 32'h2);
    chk("rst_irwrite", 32'(bus_a.IRWrite), 32'd0);
    chk("rst_pcen", 32'(bus_a.PCEn), 32'd0);
    chk("rst_cnt", bus_a.InstrCount, 32'd0);

    // lw, no wait states: 0,1,2,3,4,0
    rst_n = 1'b1; op = 6'b100011;
    settle();
    chk("lw_s0", 32'(bus_a.State), 32'd0);
    chk("lw_irwrite", 32'(bus_a.IRWrite), 32'd1);
    chk("lw_pcen", 32'(bus_a.PCEn), 32'd1);
    tick(); settle();
    chk("lw_s1", 32'(bus_a.State), 32'd1);
    chk("lw_dec_srcb", 32'(bus_a.ALUSrcB), 32'd3);
    chk("lw_dec_regwr", 32'(bus_a.RegWrite), 32'd0);
    tick(); settle();
    chk("lw_s2", 32'(bus_a.State), 32'd2);
    chk("lw_adr_srcb", 32'(bus_a.ALUSrcB), 32'd2);
    chk("lw_adr_srca", 32'(bus_a.ALUSrcA), 32'd1);
    tick(); settle();
    chk("lw_s3", 32'(bus_a.State), 32'd3);
    chk("lw_rd_iord", 32'(bus_a.IorD), 32'd1);
    chk("lw_rd_regwr", 32'(bus_a.RegWrite), 32'd0);
    tick(); settle();
    chk("lw_s4", 32'(bus_a.State), 32'd4);
    chk("lw_wb_regwr", 32'(bus_a.RegWrite), 32'd1);
    chk("lw_wb_memtoreg", 32'(bus_a.MemtoReg), 32'd1);
    chk("lw_wb_regdst", 32'(bus_a.RegDst), 32'd0);
    chk("lw_cnt", bus_a.InstrCount, 32'd1);
    tick(); settle();
    chk("lw_s5", 32'(bus_a.State), 32'd0);

    // sw with MemReady low for 3 cycles in MEMWR
    op = 6'b101011;
    tick(); tick();
    mr = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mr = 1'b1;
      settle();
      chk("sw_state", 32'(bus_a.State), 32'd5);
      chk("sw_memwrite", 32'(bus_a.MemWrite), 32'd1);
      chk("sw_regwrite", 32'(bus_a.RegWrite), 32'd0);
      tick();
    end
    settle();
    chk("sw_back_fetch", 32'(bus_a.State), 32'd0);
    chk("sw_fetch_memwr", 32'(bus_a.MemWrite), 32'd0);
    chk("sw_cnt", bus_a.InstrCount, 32'd2);

    // R-type sub then slt
    op = 6'b000000; funct = 6'b100010;
    tick(); tick(); settle();
    chk("sub_state", 32'(bus_a.State), 32'd6);
    chk("sub_aluctl", 32'(bus_a.ALUControl), 32'h6);
    chk("sub_aluctl_w6", 32'(bus_b.ALUControl), 32'h06);
    chk("sub_srcb", 32'(bus_a.ALUSrcB), 32'd0);
    chk("sub_illegal", 32'(bus_a.IllegalOp), 32'd0);
    tick(); settle();
    chk("sub_wb_state", 32'(bus_a.State), 32'd7);
    chk("sub_wb_regdst", 32'(bus_a.RegDst), 32'd1);
    chk("sub_wb_regwr", 32'(bus_a.RegWrite), 32'd1);
    tick();
    funct = 6'b101010;
    tick(); tick(); settle();
    chk("slt_aluctl", 32'(bus_a.ALUControl), 32'h7);
    chk("slt_aluctl_w6", 32'(bus_b.ALUControl), 32'h07);
    tick(); settle();
    chk("slt_wb_regdst", 32'(bus_a.RegDst), 32'd1);
    tick(); settle();
    chk("slt_back_fetch", 32'(bus_a.State), 32'd0);

    // beq taken then not taken, 3 cycles each
    op = 6'b000100; zero = 1'b1;
    tick(); tick(); settle();
    chk("beq1_state", 32'(bus_a.State), 32'd8);
    chk("beq1_pcen", 32'(bus_a.PCEn), 32'd1);
    chk("beq1_pcsrc", 32'(bus_a.PCSrc), 32'd1);
    chk("beq1_aluctl", 32'(bus_a.ALUControl), 32'h6);
    tick(); settle();
    chk("beq1_back", 32'(bus_a.State), 32'd0);
    zero = 1'b0;
    tick(); tick(); settle();
    chk("beq0_state", 32'(bus_a.State), 32'd8);
    chk("beq0_pcen", 32'(bus_a.PCEn), 32'd0);
    chk("beq0_pcsrc", 32'(bus_a.PCSrc), 32'd1);
    tick(); settle();
    chk("beq0_back", 32'(bus_a.State), 32'd0);
    chk("beq_cnt", bus_a.InstrCount, 32'd6);

    // illegal opcode 111111
    op = 6'b111111;
    tick(); settle();
    chk("ill_state", 32'(bus_a.State), 32'd1);
    chk("ill_pulse", 32'(bus_a.IllegalOp), 32'd1);
    chk("ill_memwr", 32'(bus_a.MemWrite), 32'd0);
    chk("ill_regwr", 32'(bus_a.RegWrite), 32'd0);
    tick(); settle();
    chk("ill_back", 32'(bus_a.State), 32'd0);
    chk("ill_pulse_end", 32'(bus_a.IllegalOp), 32'd0);

    // bne: legal only with the optional feature
    op = 6'b000101; zero = 1'b0;
    tick(); settle();
`ifdef MIPS_MC_CTRL_BNE_EN
    chk("bne_dec_illegal", 32'(bus_a.IllegalOp), 32'd0);
    tick(); settle();
    chk("bne_state", 32'(bus_a.State), 32'd8);
    chk("bne_pcen", 32'(bus_a.PCEn), 32'd1);
    tick(); settle();
`else
    chk("bne_dec_illegal", 32'(bus_a.IllegalOp), 32'd1);
    tick(); settle();
`endif
    chk("bne_back", 32'(bus_a.State), 32'd0);

    // unknown Funct: ADD with IllegalOp in EXEC
    op = 6'b000000; funct = 6'b111111;
    tick(); tick(); settle();
    chk("badfn_state", 32'(bus_a.State), 32'd6);
    chk("badfn_illegal", 32'(bus_a.IllegalOp), 32'd1);
    chk("badfn_aluctl", 32'(bus_a.ALUControl), 32'h2);
    tick(); tick();

    // addi
    op = 6'b001000;
    tick(); tick(); settle();
    chk("addi_ex_state", 32'(bus_a.State), 32'd9);
    chk("addi_ex_srcb", 32'(bus_a.ALUSrcB), 32'd2);
    tick(); settle();
    chk("addi_wb_state", 32'(bus_a.State), 32'd10);
    chk("addi_wb_regwr", 32'(bus_a.RegWrite), 32'd1);
    chk("addi_wb_regdst", 32'(bus_a.RegDst), 32'd0);
    tick();

    // j
    op = 6'b000010;
    tick(); tick(); settle();
    chk("j_state", 32'(bus_a.State), 32'd11);
    chk("j_pcen", 32'(bus_a.PCEn), 32'd1);
    chk("j_pcsrc", 32'(bus_a.PCSrc), 32'd2);
    tick(); settle();
    chk("j_cnt", bus_a.InstrCount, 32'd11);

    // reset in MEMREAD abandons the lw
    op = 6'b100011;
    tick(); tick();
    mr = 1'b0;
    tick(); settle();
    chk("rmid_state", 32'(bus_a.State), 32'd3);
    rst_n = 1'b0;
    settle();
    chk("rmid_in_rst_regwr", 32'(bus_a.RegWrite), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rmid_state_after", 32'(bus_a.State), 32'd0);
    chk("rmid_cnt", bus_a.InstrCount, 32'd0);
    chk("rmid_regwr", 32'(bus_a.RegWrite), 32'd0);
    tick(); settle();
    chk("rmid_hold_fetch", 32'(bus_a.State), 32'd0);

    // counter wrap on the CNT_W=4 instance: 15 jumps, then one more
    op = 6'b000010; mr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick();
    end
    settle();
    chk("wrap_pre_b", 32'(bus_b.InstrCount), 32'hF);
    chk("wrap_pre_a", bus_a.InstrCount, 32'd15);
    tick(); tick(); tick(); settle();
    chk("wrap_post_b", 32'(bus_b.InstrCount), 32'h0);
    chk("wrap_post_a", bus_a.InstrCount, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
